// File: rtl/seq_datapath.sv
// Single-bus datapath with a built-in micro-sequencer: one command runs Y -> ALU/Z -> writeback.
// Latency 1 (LDI/MFHI/MFLO/NOP), 3 (ALU ops), 4 (MUL) cycles to done; cmd_ready only while idle.
module seq_datapath #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int R0_ZERO    = 0
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [3:0]                  cmd_op,
  input  logic [$clog2(NUM_REGS)-1:0] cmd_rd,
  input  logic [$clog2(NUM_REGS)-1:0] cmd_rs,
  input  logic [$clog2(NUM_REGS)-1:0] cmd_rt,
  input  logic [DATA_WIDTH-1:0]       cmd_imm,
  output logic                        done,
  output logic [DATA_WIDTH-1:0]       result,
  output logic [DATA_WIDTH-1:0]       hi_out,
  output logic [DATA_WIDTH-1:0]       lo_out,
  output logic [DATA_WIDTH-1:0]       bus_out
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int DW = DATA_WIDTH;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_LDI  = 4'd8;
  localparam logic [3:0] OP_MFHI = 4'd9;
  localparam logic [3:0] OP_MFLO = 4'd10;

  typedef enum logic [2:0] {IDLE, S_Y, S_Z, S_WB, S_HI} state_t;

  state_t            state, state_nxt;
  logic [3:0]        op_q;
  logic [AW-1:0]     rd_q, rs_q, rt_q;
  logic [DW-1:0]     imm_q;
  logic [DW-1:0]     regs [NUM_REGS];
  logic [DW-1:0]     y_q, hi_q, lo_q, result_q;
  logic [2*DW-1:0]   z_q;
  logic              done_q;
  logic [DW-1:0]     bus;
  logic [DW-1:0]     rs_val, rt_val;
  logic [DW-1:0]     alu_lo;
  logic [2*DW-1:0]   alu_out;
  logic [SW-1:0]     shamt;
  logic              accept, is_mul, wr_rd, rd_keep;

  assign cmd_ready = (state == IDLE) && clear;
  assign accept    = cmd_valid && cmd_ready;
  assign is_mul    = (op_q == OP_MUL);
  assign wr_rd     = (op_q <= OP_SHR) || (op_q >= OP_LDI && op_q <= OP_MFLO);
  // In zero-register mode index 0 is hardwired: reads give 0, writes vanish.
  assign rd_keep   = !(R0_ZERO != 0 && rd_q == '0);
  assign rs_val    = (R0_ZERO != 0 && rs_q == '0) ? '0 : regs[rs_q];
  assign rt_val    = (R0_ZERO != 0 && rt_q == '0) ? '0 : regs[rt_q];

  always_comb begin
    bus = '0;
    case (state)
      S_Y:  bus = rs_val;
      S_Z:  bus = rt_val;
      S_WB: begin
        if (!op_q[3]) begin
          bus = z_q[DW-1:0];
        end else begin
          case (op_q)
            OP_LDI:  bus = imm_q;
            OP_MFHI: bus = hi_q;
            OP_MFLO: bus = lo_q;
            default: bus = '0;
          endcase
        end
      end
      S_HI:    bus = z_q[2*DW-1:DW];
      default: bus = '0;
    endcase
  end

  assign shamt = bus[SW-1:0];

  always_comb begin
    alu_lo = '0;
    case (op_q)
      OP_ADD:  alu_lo = y_q + bus;
      OP_SUB:  alu_lo = y_q - bus;
      OP_AND:  alu_lo = y_q & bus;
      OP_OR:   alu_lo = y_q | bus;
      OP_XOR:  alu_lo = y_q ^ bus;
      OP_SHL:  alu_lo = y_q << shamt;
      OP_SHR:  alu_lo = y_q >> shamt;
      default: alu_lo = '0;
    endcase
    if (is_mul) begin
      alu_out = {{DW{1'b0}}, y_q} * {{DW{1'b0}}, bus};
    end else begin
      alu_out = {{DW{1'b0}}, alu_lo};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = cmd_op[3] ? S_WB : S_Y;
      end
      S_Y:     state_nxt = S_Z;
      S_Z:     state_nxt = S_WB;
      S_WB:    state_nxt = is_mul ? S_HI : IDLE;
      S_HI:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      y_q      <= '0;
      z_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      done_q <= ((state == S_WB) && !is_mul) || (state == S_HI);
      if (accept) begin
        op_q  <= cmd_op;
        rd_q  <= cmd_rd;
        rs_q  <= cmd_rs;
        rt_q  <= cmd_rt;
        imm_q <= cmd_imm;
      end
      case (state)
        S_Y: y_q <= bus;
        S_Z: z_q <= alu_out;
        S_WB: begin
          if (wr_rd && rd_keep) regs[rd_q] <= bus;
          if (is_mul) lo_q <= bus;
          else        result_q <= bus;
        end
        S_HI: begin
          // LO was loaded one edge earlier, so it already holds the low product half.
          hi_q     <= bus;
          result_q <= lo_q;
        end
        default: ;
      endcase
    end
  end

  assign done    = done_q;
  assign result  = result_q;
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign bus_out = bus;

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed plan steps plus random commands against an
// arithmetic reference model; one normal build and one zero-register build.
module tb_seq_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic        a_valid, z_valid;
  logic [3:0]  cmd_op, cmd_rd, cmd_rs, cmd_rt;
  logic [31:0] cmd_imm;

  logic        a_ready, a_done, z_ready, z_done;
  logic [31:0] a_result, a_hi, a_lo, a_bus;
  logic [31:0] z_result, z_hi, z_lo, z_bus;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [2][16];
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  logic [31:0] m_res [2];

  always #5 clock = ~clock;

  seq_datapath #(.DATA_WIDTH(32), .NUM_REGS(16), .R0_ZERO(0)) dut_a (
    .clock(clock), .clear(clear), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm(cmd_imm), .done(a_done), .result(a_result), .hi_out(a_hi),
    .lo_out(a_lo), .bus_out(a_bus)
  );

  seq_datapath #(.DATA_WIDTH(32), .NUM_REGS(16), .R0_ZERO(1)) dut_z (
    .clock(clock), .clear(clear), .cmd_valid(z_valid), .cmd_ready(z_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm(cmd_imm), .done(z_done), .result(z_result), .hi_out(z_hi),
    .lo_out(z_lo), .bus_out(z_bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 16; r++) m_regs[d][r] = 32'h0;
      m_hi[d]  = 32'h0;
      m_lo[d]  = 32'h0;
      m_res[d] = 32'h0;
    end
  endtask

  // Issue one command at the current low phase (DUT must be idle) and follow it to done.
  task automatic exec(input bit z, input logic [3:0] op, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [3:0] rt,
                      input logic [31:0] imm, input bit keep);
    int          d;
    int          lat;
    logic [31:0] a, b, res;
    logic [63:0] p;
    bit          wr;
    d  = z ? 1 : 0;
    chk("ready_at_issue", z ? z_ready : a_ready, 1'b1);
    a  = (z && rs == 0) ? 32'h0 : m_regs[d][rs];
    b  = (z && rt == 0) ? 32'h0 : m_regs[d][rt];
    wr = 1'b1;
    res = 32'h0;
    lat = (op <= 6) ? 3 : (op == 7) ? 4 : 1;
    case (op)
      4'd0:  res = a + b;
      4'd1:  res = a - b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = a << b[4:0];
      4'd6:  res = a >> b[4:0];
      4'd7: begin
        p = 64'(a) * 64'(b);
        res = p[31:0];
        wr  = 1'b0;
      end
      4'd8:  res = imm;
      4'd9:  res = m_hi[d];
      4'd10: res = m_lo[d];
      default: begin
        res = 32'h0;
        wr  = 1'b0;
      end
    endcase
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
    a_valid = !z;
    z_valid = z;
    @(posedge clock);
    #1;
    if (!keep) begin
      a_valid = 1'b0;
      z_valid = 1'b0;
    end
    // Fields change while busy; a correct DUT ignores them.
    cmd_op = 4'($urandom); cmd_rd = 4'($urandom); cmd_rs = 4'($urandom);
    cmd_rt = 4'($urandom); cmd_imm = $urandom;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clock);
      chk("done_timing", z ? z_done : a_done, 1'(k == lat + 1));
      chk("ready_timing", z ? z_ready : a_ready, 1'(k == lat + 1));
    end
    if (op == 7) begin
      m_lo[d] = p[31:0];
      m_hi[d] = p[63:32];
    end
    if (wr && !(z && rd == 0)) m_regs[d][rd] = res;
    m_res[d] = res;
    chk("result", z ? z_result : a_result, m_res[d]);
    chk("hi", z ? z_hi : a_hi, m_hi[d]);
    chk("lo", z ? z_lo : a_lo, m_lo[d]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    clear = 1'b0; a_valid = 1'b0; z_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0; cmd_imm = '0;
    model_reset();

    repeat (2) @(negedge clock);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_result", a_result, 32'h0);
    chk("rst_hi", a_hi, 32'h0);
    chk("rst_lo", a_lo, 32'h0);
    chk("rst_bus", a_bus, 32'h0);
    clear = 1'b1;
    #1;
    chk("rel_ready_a", a_ready, 1'b1);
    chk("rel_ready_z", z_ready, 1'b1);

    // Directed plan
    exec(0, 4'd8, 4'd3, 4'd0, 4'd0, 32'h0000_0005, 0);
    chk("plan_ldi5", a_result, 32'h5);
    exec(0, 4'd8, 4'd4, 4'd0, 4'd0, 32'hFFFF_FFFF, 0);
    exec(0, 4'd0, 4'd5, 4'd3, 4'd4, 32'h0, 0);
    chk("plan_add_wrap", a_result, 32'h4);
    exec(0, 4'd8, 4'd7, 4'd0, 4'd0, 32'h0000_0024, 0);
    exec(0, 4'd5, 4'd6, 4'd3, 4'd7, 32'h0, 0);
    chk("plan_shl", a_result, 32'h50);
    exec(0, 4'd1, 4'd8, 4'd3, 4'd4, 32'h0, 0);
    chk("plan_sub", a_result, 32'h6);
    exec(0, 4'd7, 4'd2, 4'd4, 4'd4, 32'h0, 0);
    chk("plan_mul_lo", a_lo, 32'h0000_0001);
    chk("plan_mul_hi", a_hi, 32'hFFFF_FFFE);
    exec(0, 4'd9, 4'd9, 4'd0, 4'd0, 32'h0, 0);
    chk("plan_mfhi", a_result, 32'hFFFF_FFFE);
    exec(0, 4'd10, 4'd10, 4'd0, 4'd0, 32'h0, 0);
    exec(0, 4'd12, 4'd11, 4'd3, 4'd3, 32'hDEAD_BEEF, 0);
    chk("plan_nop", a_result, 32'h0);
    exec(0, 4'd0, 4'd3, 4'd3, 4'd3, 32'h0, 0);
    chk("plan_overlap", a_result, 32'hA);
    exec(0, 4'd6, 4'd12, 4'd4, 4'd7, 32'h0, 0);

    // Zero-register build
    exec(1, 4'd8, 4'd0, 4'd0, 4'd0, 32'h0000_1234, 0);
    chk("r0_ldi", z_result, 32'h1234);
    exec(1, 4'd0, 4'd1, 4'd0, 4'd0, 32'h0, 0);
    chk("r0_add", z_result, 32'h0);
    exec(1, 4'd8, 4'd1, 4'd0, 4'd0, 32'h0000_0007, 0);
    exec(1, 4'd0, 4'd2, 4'd1, 4'd0, 32'h0, 0);
    chk("r0_add_mixed", z_result, 32'h7);

    // Continuous cmd_valid: one acceptance per done, busy cycles ignored
    exec(0, 4'd8, 4'd1, 4'd0, 4'd0, 32'h0000_0003, 1);
    exec(0, 4'd0, 4'd2, 4'd1, 4'd3, 32'h0, 1);
    exec(0, 4'd7, 4'd0, 4'd2, 4'd1, 32'h0, 1);
    exec(0, 4'd10, 4'd6, 4'd0, 4'd0, 32'h0, 1);
    exec(0, 4'd14, 4'd6, 4'd0, 4'd0, 32'h0, 1);
    exec(0, 4'd6, 4'd5, 4'd4, 4'd1, 32'h0, 0);

    // Reset in the middle of a MUL (S_Z)
    chk("mul_rst_ready", a_ready, 1'b1);
    cmd_op = 4'd7; cmd_rd = 4'd0; cmd_rs = 4'd4; cmd_rt = 4'd3; cmd_imm = 32'h0;
    a_valid = 1'b1;
    @(posedge clock);
    #1;
    a_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("sz_bus_rt", a_bus, m_regs[0][3]);
    clear = 1'b0;
    #1;
    chk("mid_rst_done", a_done, 1'b0);
    chk("mid_rst_ready", a_ready, 1'b0);
    chk("mid_rst_result", a_result, 32'h0);
    chk("mid_rst_hi", a_hi, 32'h0);
    chk("mid_rst_lo", a_lo, 32'h0);
    chk("mid_rst_bus", a_bus, 32'h0);
    chk("mid_rst_z_result", z_result, 32'h0);
    model_reset();
    @(negedge clock);
    clear = 1'b1;
    #1;
    chk("post_rst_ready", a_ready, 1'b1);
    chk("post_rst_hi", a_hi, 32'h0);
    chk("post_rst_lo", a_lo, 32'h0);
    @(negedge clock);
    chk("abandoned_no_done", a_done, 1'b0);
    exec(0, 4'd0, 4'd5, 4'd3, 4'd4, 32'h0, 0);
    chk("regs_cleared", a_result, 32'h0);

    // Random commands on both builds
    for (int n = 0; n < 60; n++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        a_valid = 1'b0;
        z_valid = 1'b0;
        repeat (gap) @(negedge clock);
      end
      exec(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), $urandom, 1'($urandom_range(0, 1)));
    end
    a_valid = 1'b0;
    z_valid = 1'b0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
